// File: rtl/axi_mem_wrapper.sv
// AXI4 memory slave over a 64-bit word array. One burst is in flight at a
// time. Writes use byte strobes, reads come from a registered memory port,
// and any address wraps modulo MEM_SIZE.

module axi_mem_wrapper_ram #(
    parameter int    DEPTH     = 8192,
    parameter int    AW        = 13
) (
    input  logic          clk,
    input  logic          we,
    input  logic [7:0]    wstrb,
    input  logic [63:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] addr,
    output logic [63:0]   rdata
);
    logic [63:0] mem [DEPTH];

    // Byte-strobed write and registered read, sharing one word address.
    // NOTE: the array has no reset; its contents survive rst and stay undefined unless preloaded.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 8; b++) begin
                if (wstrb[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (re) rdata <= mem[addr];
    end
endmodule

module axi_mem_wrapper #(
    parameter int    ID_WIDTH  = 2,
    parameter int    MEM_SIZE  = 32'h10000,
    parameter string INIT_FILE = ""
) (
    input  logic                clk,
    input  logic                rst,
    // write address channel
    input  logic [ID_WIDTH-1:0] i_awid,
    input  logic [31:0]         i_awaddr,
    input  logic [7:0]          i_awlen,
    input  logic [2:0]          i_awsize,
    input  logic [1:0]          i_awburst,
    input  logic                i_awvalid,
    output logic                o_awready,
    // read address channel
    input  logic [ID_WIDTH-1:0] i_arid,
    input  logic [31:0]         i_araddr,
    input  logic [7:0]          i_arlen,
    input  logic [2:0]          i_arsize,
    input  logic [1:0]          i_arburst,
    input  logic                i_arvalid,
    output logic                o_arready,
    // write data channel
    input  logic [63:0]         i_wdata,
    input  logic [7:0]          i_wstrb,
    input  logic                i_wlast,
    input  logic                i_wvalid,
    output logic                o_wready,
    // write response channel
    output logic [ID_WIDTH-1:0] o_bid,
    output logic [1:0]          o_bresp,
    output logic                o_bvalid,
    input  logic                i_bready,
    // read data channel
    output logic [ID_WIDTH-1:0] o_rid,
    output logic [63:0]         o_rdata,
    output logic [1:0]          o_rresp,
    output logic                o_rlast,
    output logic                o_rvalid,
    input  logic                i_rready
);
    localparam int DEPTH = MEM_SIZE / 8;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_WRESP = 2'd2;
    localparam logic [1:0] S_READ  = 2'd3;

    localparam logic [1:0] BURST_FIXED = 2'b00;

    logic [1:0]          state, next_state;
    logic [ID_WIDTH-1:0] id_q;
    logic [31:0]         addr_q;
    logic [7:0]          len_q;
    logic [2:0]          size_q;
    logic [1:0]          burst_q;
    logic [7:0]          beat_q;

    logic                aw_hs, ar_hs, w_hs, b_hs, r_hs;
    logic                ram_re;
    logic [31:0]         next_addr;
    logic [31:0]         word_full;
    logic [AW-1:0]       word_idx;
    logic                unused_bits;

    // Only IDLE accepts addresses; a pending write request masks a read request.
    assign o_awready = !rst && (state == S_IDLE) && i_awvalid;
    assign o_arready = !rst && (state == S_IDLE) && !i_awvalid && i_arvalid;
    assign o_wready  = !rst && (state == S_WRITE);
    assign o_bvalid  = !rst && (state == S_WRESP);
    assign o_bid     = id_q;
    assign o_rid     = id_q;
    assign o_bresp   = 2'b00;
    assign o_rresp   = 2'b00;

    assign aw_hs = i_awvalid && o_awready;
    assign ar_hs = i_arvalid && o_arready;
    assign w_hs  = i_wvalid && o_wready;
    assign b_hs  = o_bvalid && i_bready;
    assign r_hs  = o_rvalid && i_rready;

    // A new read beat is fetched only once the previous one has been taken,
    // so the registered RAM output doubles as a stable rdata holding register.
    assign ram_re = (state == S_READ) && !o_rvalid;

    // FIXED bursts stay on one address; INCR and everything else step by 2^size.
    assign next_addr = (burst_q == BURST_FIXED) ? addr_q : addr_q + (32'd1 << size_q);

    // Out-of-range addresses fold back into the array instead of erroring.
    assign word_full   = (addr_q % 32'(MEM_SIZE)) >> 3;
    assign word_idx    = word_full[AW-1:0];
    // The beat count comes from len, so wlast carries no information here.
    assign unused_bits = ^{word_full[31:AW], i_wlast};

    axi_mem_wrapper_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) ram (
        .clk   (clk),
        .we    (w_hs),
        .wstrb (i_wstrb),
        .wdata (i_wdata),
        .re    (ram_re),
        .addr  (word_idx),
        .rdata (o_rdata)
    );

    // Next-state selection for the one-transaction-at-a-time controller.
    always_comb begin
        // NOTE: assigning the default first keeps this block free of inferred latches.
        next_state = state;
        case (state)
            S_IDLE: begin
                if (aw_hs)      next_state = S_WRITE;
                else if (ar_hs) next_state = S_READ;
            end
            S_WRITE: if (w_hs && (beat_q == len_q)) next_state = S_WRESP;
            S_WRESP: if (b_hs) next_state = S_IDLE;
            S_READ:  if (r_hs && o_rlast) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Control state and read-channel valid/last, cleared by reset.
    // NOTE: non-blocking assignments make every register here sample pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            o_rvalid <= 1'b0;
            o_rlast  <= 1'b0;
        end else begin
            state <= next_state;
            if (ram_re) begin
                o_rvalid <= 1'b1;
                o_rlast  <= (beat_q == len_q);
            end else if (r_hs) begin
                o_rvalid <= 1'b0;
                o_rlast  <= 1'b0;
            end
        end
    end

    // Burst context: captured at the address handshake, advanced once per beat.
    always_ff @(posedge clk) begin
        if (aw_hs) begin
            id_q    <= i_awid;
            addr_q  <= i_awaddr;
            len_q   <= i_awlen;
            size_q  <= i_awsize;
            burst_q <= i_awburst;
            beat_q  <= 8'd0;
        end else if (ar_hs) begin
            id_q    <= i_arid;
            addr_q  <= i_araddr;
            len_q   <= i_arlen;
            size_q  <= i_arsize;
            burst_q <= i_arburst;
            beat_q  <= 8'd0;
        end else if (w_hs || ram_re) begin
            addr_q <= next_addr;
            beat_q <= beat_q + 8'd1;
        end
    end
endmodule

// File: tb/tb_axi_mem_wrapper.sv
// Directed bench for axi_mem_wrapper: reset values, single and strobed
// writes, INCR/FIXED/narrow bursts, read backpressure, write-over-read
// arbitration with address wrap, and reset in the middle of a burst.

module tb_axi_mem_wrapper;
    localparam int MEM_SIZE = 32'h10000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  i_awid = '0, i_arid = '0;
    logic [31:0] i_awaddr = '0, i_araddr = '0;
    logic [7:0]  i_awlen = '0, i_arlen = '0;
    logic [2:0]  i_awsize = '0, i_arsize = '0;
    logic [1:0]  i_awburst = '0, i_arburst = '0;
    logic        i_awvalid = 1'b0, i_arvalid = 1'b0;
    logic [63:0] i_wdata = '0;
    logic [7:0]  i_wstrb = '0;
    logic        i_wlast = 1'b0, i_wvalid = 1'b0, i_bready = 1'b0, i_rready = 1'b0;
    logic        o_awready, o_arready, o_wready, o_bvalid, o_rlast, o_rvalid;
    logic [1:0]  o_bid, o_bresp, o_rid, o_rresp;
    logic [63:0] o_rdata;

    int compared = 0;
    int mismatched = 0;

    // write-helper inputs and observations
    logic [63:0] wr_data [4];
    logic [7:0]  wr_strb [4];
    int          wr_timeout, wr_ar_leak, wr_b_drop, wr_aw_wait;
    logic        wr_b_seen;
    logic [1:0]  wr_bid, wr_bresp;

    // read-helper observations
    logic [63:0] rd_data [16];
    logic        rd_last [16];
    logic [1:0]  rd_id [16];
    int          rd_count, rd_unstable, rd_first_lat, rd_timeout, rd_stalls, rd_ar_wait, rd_resp_bad;
    logic        rd_extra;

    axi_mem_wrapper #(.ID_WIDTH(2), .MEM_SIZE(MEM_SIZE), .INIT_FILE("")) dut (
        .clk(clk), .rst(rst),
        .i_awid(i_awid), .i_awaddr(i_awaddr), .i_awlen(i_awlen), .i_awsize(i_awsize),
        .i_awburst(i_awburst), .i_awvalid(i_awvalid), .o_awready(o_awready),
        .i_arid(i_arid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize),
        .i_arburst(i_arburst), .i_arvalid(i_arvalid), .o_arready(o_arready),
        .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wlast(i_wlast), .i_wvalid(i_wvalid), .o_wready(o_wready),
        .o_bid(o_bid), .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
        .o_rid(o_rid), .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rlast(o_rlast),
        .o_rvalid(o_rvalid), .i_rready(i_rready)
    );

    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // Full write burst starting and ending at a falling edge. Optionally raises
    // arvalid alongside awvalid and holds bready low for b_delay cycles.
    task automatic axi_write(input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input bit with_ar, input int b_delay);
        int n;
        wr_timeout = 0; wr_ar_leak = 0; wr_b_drop = 0; wr_aw_wait = 0; wr_b_seen = 1'b0;
        i_awid = id; i_awaddr = addr; i_awlen = len; i_awsize = size; i_awburst = burst;
        i_awvalid = 1'b1;
        if (with_ar) i_arvalid = 1'b1;
        #1;
        n = 0;
        while (o_awready !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
        wr_aw_wait = n;
        if (o_awready !== 1'b1) wr_timeout++;
        if (o_arready === 1'b1) wr_ar_leak++;
        @(negedge clk);
        i_awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            i_wvalid = 1'b1; i_wdata = wr_data[b]; i_wstrb = wr_strb[b]; i_wlast = (b == int'(len));
            #1;
            n = 0;
            while (o_wready !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
            if (o_wready !== 1'b1) wr_timeout++;
            if (o_arready === 1'b1) wr_ar_leak++;
            @(negedge clk);
        end
        i_wvalid = 1'b0; i_wlast = 1'b0;
        n = 0;
        while (o_bvalid !== 1'b1 && n < 50) begin
            if (o_arready === 1'b1) wr_ar_leak++;
            @(negedge clk); n++;
        end
        wr_b_seen = o_bvalid;
        if (o_bvalid !== 1'b1) wr_timeout++;
        for (int k = 0; k < b_delay; k++) begin
            if (o_arready === 1'b1) wr_ar_leak++;
            @(negedge clk);
            if (o_bvalid !== 1'b1) wr_b_drop++;
        end
        if (o_arready === 1'b1) wr_ar_leak++;
        wr_bid = o_bid; wr_bresp = o_bresp;
        i_bready = 1'b1;
        @(negedge clk);
        i_bready = 1'b0;
    endtask

    // Full read burst starting and ending at a falling edge. Withholds rready
    // for stall_cycles cycles while beat stall_beat is on the bus.
    task automatic axi_read(input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int stall_beat, input int stall_cycles);
        int n, cyc, beat, stall;
        bit holding;
        logic [63:0] held_data;
        logic held_last;
        rd_count = 0; rd_unstable = 0; rd_first_lat = 0; rd_timeout = 0; rd_stalls = 0;
        rd_ar_wait = 0; rd_resp_bad = 0; rd_extra = 1'b0;
        held_data = '0; held_last = 1'b0;
        i_arid = id; i_araddr = addr; i_arlen = len; i_arsize = size; i_arburst = burst;
        i_arvalid = 1'b1; i_rready = 1'b0;
        #1;
        n = 0;
        while (o_arready !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
        rd_ar_wait = n;
        if (o_arready !== 1'b1) rd_timeout++;
        @(posedge clk);
        cyc = 0; beat = 0; stall = 0; holding = 1'b0;
        while (beat <= int'(len) && cyc < 200) begin
            @(negedge clk);
            cyc++;
            i_arvalid = 1'b0;
            if (holding && (o_rvalid !== 1'b1 || o_rdata !== held_data || o_rlast !== held_last))
                rd_unstable++;
            holding = 1'b0;
            if (o_rvalid === 1'b1) begin
                if (rd_first_lat == 0) rd_first_lat = cyc;
                if (o_rresp !== 2'b00) rd_resp_bad++;
                if (beat == stall_beat && stall < stall_cycles) begin
                    i_rready = 1'b0; stall++; holding = 1'b1;
                    held_data = o_rdata; held_last = o_rlast;
                end else begin
                    i_rready = 1'b1;
                    rd_data[beat] = o_rdata; rd_last[beat] = o_rlast; rd_id[beat] = o_rid;
                    beat++;
                end
            end else begin
                i_rready = 1'b0;
            end
        end
        if (beat <= int'(len)) rd_timeout++;
        rd_count = beat; rd_stalls = stall;
        @(negedge clk);
        i_rready = 1'b0;
        rd_extra = (o_rvalid === 1'b1);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        compared++; if (o_awready !== 1'b0) begin mismatched++; $display("FAIL reset_awready: got %b want 0", o_awready); end
        compared++; if (o_arready !== 1'b0) begin mismatched++; $display("FAIL reset_arready: got %b want 0", o_arready); end
        compared++; if (o_wready !== 1'b0) begin mismatched++; $display("FAIL reset_wready: got %b want 0", o_wready); end
        compared++; if (o_bvalid !== 1'b0) begin mismatched++; $display("FAIL reset_bvalid: got %b want 0", o_bvalid); end
        compared++; if (o_rvalid !== 1'b0) begin mismatched++; $display("FAIL reset_rvalid: got %b want 0", o_rvalid); end
        compared++; if (o_rlast !== 1'b0) begin mismatched++; $display("FAIL reset_rlast: got %b want 0", o_rlast); end
        compared++; if (o_bresp !== 2'b00 || o_rresp !== 2'b00) begin mismatched++; $display("FAIL reset_resp: got %b/%b want 00/00", o_bresp, o_rresp); end
        rst = 1'b0;
        @(negedge clk);
        compared++; if (o_wready !== 1'b0 || o_bvalid !== 1'b0 || o_rvalid !== 1'b0) begin mismatched++; $display("FAIL idle_after_reset: got w%b b%b r%b want 000", o_wready, o_bvalid, o_rvalid); end
    endtask

    task automatic test_single_write;
        wr_data[0] = 64'h1122_3344_5566_7788; wr_strb[0] = 8'hFF;
        axi_write(2'd3, 32'h10, 8'd0, 3'd3, 2'b01, 1'b0, 0);
        compared++; if (wr_timeout !== 0) begin mismatched++; $display("FAIL single_w_timeout: got %0d want 0", wr_timeout); end
        compared++; if (wr_b_seen !== 1'b1) begin mismatched++; $display("FAIL single_bvalid: got %b want 1", wr_b_seen); end
        compared++; if (wr_bid !== 2'd3) begin mismatched++; $display("FAIL single_bid: got %0d want 3", wr_bid); end
        compared++; if (wr_bresp !== 2'b00) begin mismatched++; $display("FAIL single_bresp: got %b want 00", wr_bresp); end
        axi_read(2'd1, 32'h10, 8'd0, 3'd3, 2'b01, -1, 0);
        compared++; if (rd_count !== 1 || rd_timeout !== 0) begin mismatched++; $display("FAIL single_r_count: got %0d beats (timeout %0d) want 1", rd_count, rd_timeout); end
        compared++; if (rd_data[0] !== 64'h1122_3344_5566_7788) begin mismatched++; $display("FAIL single_rdata: got %h want 1122334455667788", rd_data[0]); end
        compared++; if (rd_last[0] !== 1'b1) begin mismatched++; $display("FAIL single_rlast: got %b want 1", rd_last[0]); end
        compared++; if (rd_id[0] !== 2'd1) begin mismatched++; $display("FAIL single_rid: got %0d want 1", rd_id[0]); end
        compared++; if (rd_resp_bad !== 0) begin mismatched++; $display("FAIL single_rresp: got %0d nonzero beats want 0", rd_resp_bad); end
        compared++; if (rd_first_lat !== 2) begin mismatched++; $display("FAIL read_latency: got %0d cycles want 2", rd_first_lat); end
        compared++; if (rd_extra !== 1'b0) begin mismatched++; $display("FAIL single_extra_beat: got rvalid %b after last want 0", rd_extra); end
    endtask

    task automatic test_byte_strobe;
        dut.ram.mem[4] = 64'h0;
        wr_data[0] = 64'hFFFF_FFFF_FFFF_FFFF; wr_strb[0] = 8'h0F;
        axi_write(2'd0, 32'h20, 8'd0, 3'd3, 2'b01, 1'b0, 0);
        axi_read(2'd0, 32'h20, 8'd0, 3'd3, 2'b01, -1, 0);
        compared++; if (rd_data[0] !== 64'h0000_0000_FFFF_FFFF) begin mismatched++; $display("FAIL strobe_rdata: got %h want 00000000ffffffff", rd_data[0]); end
    endtask

    task automatic test_incr_read;
        logic [63:0] exp_w [4];
        exp_w[0] = 64'hA000_0000_0000_0001; exp_w[1] = 64'hB000_0000_0000_0002;
        exp_w[2] = 64'hC000_0000_0000_0003; exp_w[3] = 64'hD000_0000_0000_0004;
        for (int i = 0; i < 4; i++) dut.ram.mem[i] = exp_w[i];
        axi_read(2'd2, 32'h0, 8'd3, 3'd3, 2'b01, -1, 0);
        compared++; if (rd_count !== 4) begin mismatched++; $display("FAIL incr_count: got %0d want 4", rd_count); end
        for (int i = 0; i < 4; i++) begin
            compared++; if (rd_data[i] !== exp_w[i]) begin mismatched++; $display("FAIL incr_data[%0d]: got %h want %h", i, rd_data[i], exp_w[i]); end
            compared++; if (rd_last[i] !== (i == 3)) begin mismatched++; $display("FAIL incr_rlast[%0d]: got %b want %b", i, rd_last[i], (i == 3)); end
            compared++; if (rd_id[i] !== 2'd2) begin mismatched++; $display("FAIL incr_rid[%0d]: got %0d want 2", i, rd_id[i]); end
        end
    endtask

    task automatic test_backpressure;
        logic [63:0] exp_w [4];
        exp_w[0] = 64'h0101_0101_0101_0101; exp_w[1] = 64'h0202_0202_0202_0202;
        exp_w[2] = 64'h0303_0303_0303_0303; exp_w[3] = 64'h0404_0404_0404_0404;
        for (int i = 0; i < 4; i++) dut.ram.mem[16 + i] = exp_w[i];
        axi_read(2'd0, 32'h80, 8'd3, 3'd3, 2'b01, 1, 5);
        compared++; if (rd_stalls !== 5) begin mismatched++; $display("FAIL bp_stalls: got %0d want 5", rd_stalls); end
        compared++; if (rd_unstable !== 0) begin mismatched++; $display("FAIL bp_stable: got %0d changes want 0", rd_unstable); end
        compared++; if (rd_count !== 4) begin mismatched++; $display("FAIL bp_count: got %0d want 4", rd_count); end
        for (int i = 0; i < 4; i++) begin
            compared++; if (rd_data[i] !== exp_w[i]) begin mismatched++; $display("FAIL bp_data[%0d]: got %h want %h", i, rd_data[i], exp_w[i]); end
        end
        compared++; if (rd_extra !== 1'b0) begin mismatched++; $display("FAIL bp_extra_beat: got %b want 0", rd_extra); end
    endtask

    task automatic test_fixed_narrow;
        dut.ram.mem[8] = 64'h1111_1111_1111_1111;
        dut.ram.mem[9] = 64'h9999_9999_9999_9999;
        wr_data[0] = 64'hAAAA_AAAA_BBBB_BBBB; wr_strb[0] = 8'h0F;
        wr_data[1] = 64'hCCCC_CCCC_DDDD_DDDD; wr_strb[1] = 8'hF0;
        axi_write(2'd1, 32'h40, 8'd1, 3'd3, 2'b00, 1'b0, 0);
        axi_read(2'd1, 32'h40, 8'd1, 3'd3, 2'b01, -1, 0);
        compared++; if (rd_data[0] !== 64'hCCCC_CCCC_BBBB_BBBB) begin mismatched++; $display("FAIL fixed_merge: got %h want ccccccccbbbbbbbb", rd_data[0]); end
        compared++; if (rd_data[1] !== 64'h9999_9999_9999_9999) begin mismatched++; $display("FAIL fixed_neighbour: got %h want 9999999999999999", rd_data[1]); end
        axi_read(2'd0, 32'h48, 8'd1, 3'd2, 2'b01, -1, 0);
        compared++; if (rd_data[0] !== 64'h9999_9999_9999_9999 || rd_data[1] !== 64'h9999_9999_9999_9999) begin mismatched++; $display("FAIL narrow_data: got %h %h want 9999999999999999 twice", rd_data[0], rd_data[1]); end
        compared++; if (rd_last[0] !== 1'b0 || rd_last[1] !== 1'b1) begin mismatched++; $display("FAIL narrow_rlast: got %b%b want 01", rd_last[0], rd_last[1]); end
    endtask

    task automatic test_simultaneous;
        dut.ram.mem[1] = 64'h0;
        wr_data[0] = 64'hCAFE_F00D_1234_5678; wr_strb[0] = 8'hFF;
        i_arid = 2'd1; i_araddr = 32'h8; i_arlen = 8'd0; i_arsize = 3'd3; i_arburst = 2'b01;
        axi_write(2'd2, MEM_SIZE + 32'h8, 8'd0, 3'd3, 2'b01, 1'b1, 3);
        compared++; if (wr_aw_wait !== 0) begin mismatched++; $display("FAIL arb_awready_first: got wait %0d want 0", wr_aw_wait); end
        compared++; if (wr_ar_leak !== 0) begin mismatched++; $display("FAIL arb_arready_early: got %0d cycles want 0", wr_ar_leak); end
        compared++; if (wr_b_drop !== 0) begin mismatched++; $display("FAIL arb_bvalid_hold: got %0d drops want 0", wr_b_drop); end
        compared++; if (wr_bid !== 2'd2) begin mismatched++; $display("FAIL arb_bid: got %0d want 2", wr_bid); end
        axi_read(2'd1, 32'h8, 8'd0, 3'd3, 2'b01, -1, 0);
        compared++; if (rd_ar_wait !== 0) begin mismatched++; $display("FAIL arb_arready_after_b: got wait %0d want 0", rd_ar_wait); end
        compared++; if (rd_data[0] !== 64'hCAFE_F00D_1234_5678) begin mismatched++; $display("FAIL wrap_data: got %h want cafef00d12345678", rd_data[0]); end
    endtask

    task automatic test_mid_reset;
        int n;
        for (int i = 0; i < 4; i++) dut.ram.mem[32 + i] = 64'h5555_0000_0000_0000 + 64'(i);
        i_awid = 2'd1; i_awaddr = 32'h100; i_awlen = 8'd3; i_awsize = 3'd3; i_awburst = 2'b01;
        i_awvalid = 1'b1;
        #1;
        n = 0;
        while (o_awready !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
        compared++; if (o_awready !== 1'b1) begin mismatched++; $display("FAIL mid_awready: got %b want 1", o_awready); end
        @(negedge clk);
        i_awvalid = 1'b0;
        i_wvalid = 1'b1; i_wdata = 64'hEEEE_0000_0000_0000; i_wstrb = 8'hFF;
        #1;
        compared++; if (o_wready !== 1'b1) begin mismatched++; $display("FAIL mid_wready: got %b want 1", o_wready); end
        @(negedge clk);
        i_wdata = 64'hEEEE_0000_0000_0001;
        @(negedge clk);
        i_wvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        compared++; if (o_wready !== 1'b0 || o_bvalid !== 1'b0) begin mismatched++; $display("FAIL mid_abort: got wready %b bvalid %b want 0 0", o_wready, o_bvalid); end
        axi_read(2'd0, 32'h100, 8'd3, 3'd3, 2'b01, -1, 0);
        compared++; if (rd_data[0] !== 64'hEEEE_0000_0000_0000 || rd_data[1] !== 64'hEEEE_0000_0000_0001) begin mismatched++; $display("FAIL mid_written: got %h %h want eeee000000000000 eeee000000000001", rd_data[0], rd_data[1]); end
        compared++; if (rd_data[2] !== 64'h5555_0000_0000_0002 || rd_data[3] !== 64'h5555_0000_0000_0003) begin mismatched++; $display("FAIL mid_untouched: got %h %h want 5555000000000002 5555000000000003", rd_data[2], rd_data[3]); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_byte_strobe();
        test_incr_read();
        test_backpressure();
        test_fixed_narrow();
        test_simultaneous();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
